// File: rtl/mainbus_arbiter.sv
// mainbus_arbiter: burst-aware round-robin arbiter for the shared 16-bit main bus.
//
// Grants one primary at a time and holds the grant for a complete transaction
// (address phase, optional read turnaround, fixed-length data burst). It tracks
// the transaction by snooping the address strobe and the direction line. After
// every transaction, at least one idle cycle passes with no grant.
//
// Ports:
//   clk_i          bus clock (same as mainbus_if.clk)
//   reset_i        synchronous, active-high reset
//   req_i          per-primary request, level-sensitive
//   addr_valid_i   snooped bus address strobe
//   rw_i           snooped direction, 1 = read, 0 = write (valid with addr_valid_i)
//   gnt_o          one-hot registered grant
//   owner_o        index of the current or last grantee
//   busy_o         high whenever the arbiter is not idle
//   timeout_err_o  one-cycle pulse when a grant is revoked by timeout
//
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant when no address
// phase arrives within TIMEOUT cycles. Without it, timeout_err_o is tied low.

module mainbus_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [NREQ-1:0]                          req_i,
  input  logic                                     addr_valid_i,
  input  logic                                     rw_i,
  output logic [NREQ-1:0]                          gnt_o,
  output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] owner_o,
  output logic                                     busy_o,
  output logic                                     timeout_err_o
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {StIdle, StGrant, StRturn, StRdata, StWdata} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              tmo_err_q, tmo_err_d;
`else
  logic              unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Round-robin search: the first requester at or after (last owner + 1) wins,
  // so the last owner has the lowest priority.
  logic              rr_found;
  logic [IdxW-1:0]   rr_winner;
  logic [IdxW-1:0]   rr_cand;

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rr_cand = IdxW'((32'(last_q) + 32'd1 + i) % NREQ);
      if (!rr_found && req_i[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          state_d            = StGrant;
          gnt_d              = '0;
          gnt_d[rr_winner]   = 1'b1;
          owner_d            = rr_winner;
          // An abandoned grant still counts as a turn.
          last_d             = rr_winner;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d          = '0;
`endif
        end
      end

      StGrant: begin
        if (addr_valid_i) begin
          if (rw_i) begin
            state_d = StRturn;
          end else begin
            state_d = StWdata;
            beat_d  = '0;
          end
        end else if (!req_i[owner_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          gnt_d     = '0;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      StRturn: begin
        state_d = StRdata;
        beat_d  = '0;
      end

      StRdata, StWdata: begin
        // Counter can reach BURST_LEN on the last beat; its width allows that.
        beat_d = beat_q + 1'b1;
        if (beat_q == BeatW'(BURST_LEN - 1)) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      // Pointer at the highest index so requester 0 wins first after reset.
      last_q  <= IdxW'(NREQ - 1);
      beat_q  <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err_o = tmo_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Testbench for mainbus_arbiter (NREQ=2, BURST_LEN=4, TIMEOUT=16).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus checked against a transaction-level reference model.

module tb_mainbus_arbiter;

  localparam int NREQ      = 2;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic            av;
  logic            rw;
  logic [NREQ-1:0] gnt;
  logic [0:0]      owner;
  logic            busy;
  logic            tmo;

  int n_cmp;
  int n_fail;
  int cyc;

  mainbus_arbiter #(
    .NREQ      (NREQ),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .addr_valid_i  (av),
    .rw_i          (rw),
    .gnt_o         (gnt),
    .owner_o       (owner),
    .busy_o        (busy),
    .timeout_err_o (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ownership plus a countdown of edges left in the transaction.
  bit m_granted;
  int m_owner;
  int m_last;
  bit m_addr_seen;
  int m_remain;
  int m_wait;
  bit m_tmo;

  function void model_edge();
    bit found;
    int c;
    m_tmo = 1'b0;
    if (reset) begin
      m_granted   = 1'b0;
      m_owner     = 0;
      m_last      = NREQ - 1;
      m_addr_seen = 1'b0;
      m_remain    = 0;
      m_wait      = 0;
    end else if (!m_granted) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!found && req[c]) begin
          found       = 1'b1;
          m_granted   = 1'b1;
          m_owner     = c;
          m_last      = c;
          m_addr_seen = 1'b0;
          m_wait      = 0;
        end
      end
    end else if (!m_addr_seen) begin
      if (av) begin
        m_addr_seen = 1'b1;
        m_remain    = rw ? BURST_LEN + 1 : BURST_LEN;
      end else if (!req[m_owner]) begin
        m_granted = 1'b0;
      end else begin
        m_wait++;
        if (TmoEn && m_wait >= TIMEOUT) begin
          m_granted = 1'b0;
          m_tmo     = 1'b1;
        end
      end
    end else begin
      m_remain--;
      if (m_remain == 0) m_granted = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [NREQ-1:0] eg;
    eg = '0;
    if (m_granted) eg[m_owner] = 1'b1;
    n_cmp++;
    if (gnt !== eg || owner !== 1'(m_owner) || busy !== m_granted || tmo !== m_tmo) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got gnt=%b owner=%0d busy=%b tmo=%b want gnt=%b owner=%0d busy=%b tmo=%b",
               name, cyc, gnt, owner, busy, tmo, eg, m_owner, m_granted, m_tmo);
    end
  endtask

  typedef struct {
    bit       rst;
    bit [1:0] rq;
    bit       a;
    bit       r;
    bit [1:0] g;
    bit       b;
    bit       o;
  } vec_t;

  vec_t tv[$];

  function void add(bit rst, bit [1:0] rq, bit a, bit r, bit [1:0] g, bit b, bit o);
    vec_t v;
    v.rst = rst; v.rq = rq; v.a = a; v.r = r; v.g = g; v.b = b; v.o = o;
    tv.push_back(v);
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    reset  = 1'b1;
    req    = '0;
    av     = 1'b0;
    rw     = 1'b0;

    // ---- Directed table: inputs before an edge, outputs expected after it ----
    add(1, 2'b00, 0, 0, 2'b00, 0, 0);  // reset
    add(0, 2'b01, 0, 0, 2'b01, 1, 0);  // request -> grant 0
    add(0, 2'b01, 1, 0, 2'b01, 1, 0);  // write address phase
    add(0, 2'b01, 0, 0, 2'b01, 1, 0);
    add(0, 2'b01, 0, 0, 2'b01, 1, 0);
    add(0, 2'b01, 0, 0, 2'b01, 1, 0);
    add(0, 2'b01, 0, 0, 2'b00, 0, 0);  // 4 edges after address: released
    add(0, 2'b11, 0, 0, 2'b10, 1, 1);  // both request, 1 wins
    add(0, 2'b11, 1, 1, 2'b10, 1, 1);  // read address phase
    for (int i = 0; i < 4; i++) add(0, 2'b11, 0, 0, 2'b10, 1, 1);
    add(0, 2'b11, 0, 0, 2'b00, 0, 1);  // 5 edges after address
    add(0, 2'b11, 0, 0, 2'b01, 1, 0);
    add(0, 2'b11, 1, 1, 2'b01, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 0, 0, 2'b01, 1, 0);
    add(0, 2'b11, 0, 0, 2'b00, 0, 0);
    add(0, 2'b11, 0, 0, 2'b10, 1, 1);
    add(0, 2'b00, 0, 0, 2'b00, 0, 1);  // grantee drops before address
    add(0, 2'b01, 0, 0, 2'b01, 1, 0);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0);  // abandoned grant to 0
    add(0, 2'b11, 0, 0, 2'b10, 1, 1);  // abandoned turn counted: 1 first
    add(0, 2'b11, 0, 0, 2'b10, 1, 1);  // waiting for address
    add(0, 2'b11, 1, 0, 2'b10, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 0, 2'b10, 1, 1);
    add(0, 2'b11, 0, 0, 2'b00, 0, 1);
    add(0, 2'b00, 1, 0, 2'b00, 0, 1);  // strobe in idle ignored
    add(0, 2'b01, 0, 0, 2'b01, 1, 0);
    add(0, 2'b01, 1, 0, 2'b01, 1, 0);
    add(0, 2'b11, 0, 0, 2'b01, 1, 0);  // 1 requests mid-burst
    add(0, 2'b11, 1, 1, 2'b01, 1, 0);  // strobe in data ignored
    add(0, 2'b11, 0, 0, 2'b01, 1, 0);
    add(0, 2'b11, 0, 0, 2'b00, 0, 0);
    add(0, 2'b11, 0, 0, 2'b10, 1, 1);

    foreach (tv[i]) begin
      reset = tv[i].rst;
      req   = tv[i].rq;
      av    = tv[i].a;
      rw    = tv[i].r;
      step();
      n_cmp++;
      if ({gnt, busy, owner, tmo} !== {tv[i].g, tv[i].b, tv[i].o, 1'b0}) begin
        n_fail++;
        $display("FAIL vec%0d got gnt=%b busy=%b owner=%0d tmo=%b want gnt=%b busy=%b owner=%0d tmo=0",
                 i, gnt, busy, owner, tmo, tv[i].g, tv[i].b, tv[i].o);
      end
    end

    // ---- Reset during read data beat 1 ----
    reset = 1'b1; req = 2'b00; av = 1'b0; rw = 1'b0;
    step();
    reset = 1'b0; req = 2'b01;
    step();
    req = 2'b00;
    step();
    req = 2'b10;
    step();
    chk("rst_seq_gnt1", 32'(gnt), 32'h2);
    av = 1'b1; rw = 1'b1;
    step();
    av = 1'b0; rw = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_owner", 32'(owner), 32'h0);
    reset = 1'b0; req = 2'b11;
    step();
    chk("rst_after_gnt", 32'(gnt), 32'h1);

    // ---- Grant held without an address phase ----
    reset = 1'b1; req = 2'b00;
    step();
    reset = 1'b0; req = 2'b01;
    step();
    chk("hold_grant", 32'(gnt), 32'h1);
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      if (i == TIMEOUT - 1) begin
        chk("hold_gnt_last", 32'(gnt), 32'h1);
        chk("hold_tmo_last", 32'(tmo), 32'h0);
      end
    end
    step();
`ifdef ARB_TIMEOUT_EN
    chk("tmo_gnt_drop", 32'(gnt), 32'h0);
    chk("tmo_pulse", 32'(tmo), 32'h1);
    step();
    chk("tmo_pulse_end", 32'(tmo), 32'h0);
    chk("tmo_regrant", 32'(gnt), 32'h1);
`else
    for (int i = TIMEOUT + 1; i < 100; i++) step();
    chk("no_tmo_gnt100", 32'(gnt), 32'h1);
    chk("no_tmo_err", 32'(tmo), 32'h0);
`endif

    // ---- Random stimulus against the reference model ----
    reset = 1'b1; req = '0; av = 1'b0; rw = 1'b0;
    step();
    check_model("rand_reset");
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      av    = ($urandom_range(5) == 0);
      rw    = 1'($urandom_range(1));
      reset = ($urandom_range(199) == 0);
      step();
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
